// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one 4x4 multiplier among NREQ requesters; one op in flight.
// Latency: request handshake in cycle 0 -> rsp_valid in cycle MUL_LAT+2; issue interval MUL_LAT+3.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready. Optional MUL_SHARE_ARBITER_STATS_EN adds ops_done.
module mul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,  // must equal clog2(NREQ)
  parameter int MUL_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [3:0]        mul_a,
  output logic [3:0]        mul_b,
  input  logic [7:0]        mul_p,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [7:0]        rsp_p,
  input  logic              rsp_ready
`ifdef MUL_SHARE_ARBITER_STATS_EN
  ,
  output logic [15:0]       ops_done
`endif
);

  localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT);
  localparam logic [ID_W:0]    NREQ_W   = (ID_W + 1)'(NREQ);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_q;
  logic [CNT_W-1:0] cnt;

  logic [NREQ-1:0]  rot;
  logic [ID_W-1:0]  off;
  logic [ID_W:0]    sum;
  logic [ID_W-1:0]  grant;
  logic             any_req;
  logic             req_hs;
  logic [3:0]       sel_a;
  logic [3:0]       sel_b;

  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, then un-rotate.
  always_comb begin
    rot = NREQ'({req_valid, req_valid} >> rr_ptr);
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = ID_W'(k);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    grant   = sum[ID_W-1:0];
    any_req = |req_valid;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_a = req_a[4*i +: 4];
        sel_b = req_b[4*i +: 4];
      end
    end
  end

  // Grant is recomputed every IDLE cycle, so a withdrawn request never sticks.
  assign req_ready = (state == IDLE && any_req) ? (NREQ'(1) << grant) : '0;
  assign req_hs    = |(req_valid & req_ready);

  // Control FSM: grant in IDLE, count out the multiplier latency, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            mul_a  <= sel_a;
            mul_b  <= sel_b;
            id_q   <= grant;
            rr_ptr <= (grant == LAST_ID) ? '0 : grant + 1'b1;
            cnt    <= CNT_INIT;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_p     <= mul_p;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUL_SHARE_ARBITER_STATS_EN
  // Completed-operation counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_done <= '0;
    end else if (state == RESP && rsp_ready && ops_done != 16'hFFFF) begin
      ops_done <= ops_done + 16'd1;
    end
  end
`endif

endmodule
